// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard for the pipelined MIPS core: in-flight producer slots, HI/LO busy tracking, owner lookup.
// Optional stall statistics counter is built when HAZARD_STATS_EN is defined.
module hazard_scoreboard #(
    parameter int NSTAGE   = 3,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int SELW     = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_d_valid,
    input  logic [4:0]      i_rs_addr,
    input  logic [4:0]      i_rt_addr,
    input  logic [TW-1:0]   i_rs_tuse,
    input  logic [TW-1:0]   i_rt_tuse,
    input  logic            i_wr_en,
    input  logic [4:0]      i_wr_addr,
    input  logic [TW-1:0]   i_wr_tnew,
    input  logic            i_md_start,
    input  logic            i_md_div,
    input  logic            i_md_use,
    input  logic            i_flush,
    output logic            o_stall,
    output logic [SELW-1:0] o_rs_owner,
    output logic [SELW-1:0] o_rt_owner,
    output logic            o_md_busy,
    output logic [31:0]     o_stall_count
);

    localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int MDW    = $clog2(MD_MAX + 1);
    localparam logic [TW-1:0] TUSE_NONE = '1;

    logic            r_valid [NSTAGE];
    logic [4:0]      r_addr  [NSTAGE];
    logic [TW-1:0]   r_tnew  [NSTAGE];
    logic [MDW-1:0]  r_md_cnt;

    logic            w_rs_match_hz;
    logic            w_rt_match_hz;
    logic            w_rs_hazard;
    logic            w_rt_hazard;
    logic            w_md_hazard;
    logic            w_stall;
    logic            w_load;
    logic            w_md_busy;
    logic [SELW-1:0] w_rs_owner;
    logic [SELW-1:0] w_rt_owner;

    // A producer blocks a source only while its result is further away than the consumer's need.
    always_comb begin
        w_rs_match_hz = 1'b0;
        w_rt_match_hz = 1'b0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (r_valid[k] && (r_addr[k] == i_rs_addr) && (r_tnew[k] > i_rs_tuse)) begin
                w_rs_match_hz = 1'b1;
            end
            if (r_valid[k] && (r_addr[k] == i_rt_addr) && (r_tnew[k] > i_rt_tuse)) begin
                w_rt_match_hz = 1'b1;
            end
        end
    end

    assign w_rs_hazard = w_rs_match_hz && (i_rs_addr != 5'd0) && (i_rs_tuse != TUSE_NONE);
    assign w_rt_hazard = w_rt_match_hz && (i_rt_addr != 5'd0) && (i_rt_tuse != TUSE_NONE);
    assign w_md_busy   = (r_md_cnt != '0);
    assign w_md_hazard = i_md_use && (w_md_busy || i_md_start);
    assign w_stall     = i_d_valid && (w_rs_hazard || w_rt_hazard || w_md_hazard);

    assign w_load = i_d_valid && !w_stall && !i_flush && i_wr_en && (i_wr_addr != 5'd0);

    // Scanning oldest to youngest lets the youngest match overwrite, giving lowest-index priority.
    always_comb begin
        w_rs_owner = '0;
        w_rt_owner = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (r_valid[k] && (r_addr[k] == i_rs_addr)) begin
                w_rs_owner = SELW'(k + 1);
            end
            if (r_valid[k] && (r_addr[k] == i_rt_addr)) begin
                w_rt_owner = SELW'(k + 1);
            end
        end
        if (i_rs_addr == 5'd0) begin
            w_rs_owner = '0;
        end
        if (i_rt_addr == 5'd0) begin
            w_rt_owner = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        r_addr[0] <= i_wr_addr;
        r_tnew[0] <= i_wr_tnew;
        for (int k = 1; k < NSTAGE; k++) begin
            r_addr[k] <= r_addr[k-1];
            r_tnew[k] <= (r_tnew[k-1] != '0) ? (r_tnew[k-1] - TW'(1)) : '0;
        end
        if (i_reset || i_flush) begin
            for (int k = 0; k < NSTAGE; k++) begin
                r_valid[k] <= 1'b0;
            end
        end else begin
            r_valid[0] <= w_load;
            for (int k = 1; k < NSTAGE; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    // Flush leaves the multiply/divide unit alone so an in-flight operation still completes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_md_cnt <= '0;
        end else if (i_md_start && !w_md_busy) begin
            r_md_cnt <= i_md_div ? MDW'(DIV_LAT) : MDW'(MULT_LAT);
        end else if (w_md_busy) begin
            r_md_cnt <= r_md_cnt - MDW'(1);
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_count <= '0;
        end else if (w_stall) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign o_stall_count = r_stall_count;
`else
    assign o_stall_count = '0;
`endif

    assign o_stall    = w_stall;
    assign o_rs_owner = w_rs_owner;
    assign o_rt_owner = w_rt_owner;
    assign o_md_busy  = w_md_busy;

endmodule
